// File: rtl/sound_event_scheduler.sv
// Single-voice arbiter for game sound events (die > hit > eat), counted in video frames,
// with a silent gap after each naturally finished sound.
module sound_event_scheduler #(
    parameter int EAT_FRAMES = 8,
    parameter int HIT_FRAMES = 12,
    parameter int DIE_FRAMES = 30,
    parameter int GAP_FRAMES = 2,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_end,
    input  logic       eat_req,
    input  logic       hit_req,
    input  logic       die_req,
    input  logic       mute,
    output logic       saw_trigger,
    output logic       square_trigger,
    output logic       noise_trigger,
    output logic       busy,
    output logic [1:0] active_id
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [1:0] ID_NONE = 2'b00;
    localparam logic [1:0] ID_EAT  = 2'b01;
    localparam logic [1:0] ID_HIT  = 2'b10;
    localparam logic [1:0] ID_DIE  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       active_reg, active_next;
    logic [2:0]       req_vec, req_prev_reg, req_edge;
    logic [2:0]       pending_reg, pending_next, clear;
    logic [1:0]       top_id;

    // Bit order everywhere: [0] eat, [1] hit, [2] die.
    assign req_vec = {die_req, hit_req, eat_req};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            assign req_edge[gi] = req_vec[gi] & ~req_prev_reg[gi];
        end
    endgenerate

    function automatic logic [CNT_W-1:0] frames_of(input logic [1:0] id);
        case (id)
            ID_DIE:  return CNT_W'(DIE_FRAMES);
            ID_HIT:  return CNT_W'(HIT_FRAMES);
            default: return CNT_W'(EAT_FRAMES);
        endcase
    endfunction

    function automatic logic [2:0] bit_of(input logic [1:0] id);
        case (id)
            ID_EAT:  return 3'b001;
            ID_HIT:  return 3'b010;
            ID_DIE:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    always_comb begin
        top_id = ID_NONE;
        if (pending_reg[2])      top_id = ID_DIE;
        else if (pending_reg[1]) top_id = ID_HIT;
        else if (pending_reg[0]) top_id = ID_EAT;
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        active_next = active_reg;
        clear       = 3'b000;
        case (state_reg)
            IDLE: begin
                if (top_id != ID_NONE) begin
                    state_next  = PLAY;
                    cnt_next    = frames_of(top_id);
                    active_next = top_id;
                    clear       = bit_of(top_id);
                end
            end
            PLAY: begin
                // Preemption outranks retrigger, which outranks frame counting.
                if (top_id > active_reg) begin
                    cnt_next    = frames_of(top_id);
                    active_next = top_id;
                    clear       = bit_of(top_id);
                end else if ((pending_reg & bit_of(active_reg)) != 3'b000) begin
                    cnt_next = frames_of(active_reg);
                    clear    = bit_of(active_reg);
                end else if (frame_end) begin
                    if (cnt_reg > CNT_ONE) begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end else if (GAP_FRAMES > 0) begin
                        state_next  = GAP;
                        cnt_next    = CNT_W'(GAP_FRAMES);
                        active_next = ID_NONE;
                    end else begin
                        state_next  = IDLE;
                        cnt_next    = '0;
                        active_next = ID_NONE;
                    end
                end
            end
            GAP: begin
                if (pending_reg[2]) begin
                    state_next  = PLAY;
                    cnt_next    = frames_of(ID_DIE);
                    active_next = ID_DIE;
                    clear       = 3'b100;
                end else if (frame_end) begin
                    if (cnt_reg > CNT_ONE) begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
            end
            default: begin
                state_next  = IDLE;
                cnt_next    = '0;
                active_next = ID_NONE;
            end
        endcase

        // A fresh edge survives a clear of the same bit in the same cycle.
        pending_next = (pending_reg & ~clear) | req_edge;

        if (mute) begin
            state_next   = IDLE;
            cnt_next     = '0;
            active_next  = ID_NONE;
            pending_next = 3'b000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            active_reg     <= ID_NONE;
            req_prev_reg   <= 3'b000;
            pending_reg    <= 3'b000;
            saw_trigger    <= 1'b0;
            square_trigger <= 1'b0;
            noise_trigger  <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            active_reg     <= active_next;
            req_prev_reg   <= req_vec;
            pending_reg    <= pending_next;
            saw_trigger    <= (state_next == PLAY) && (active_next == ID_EAT);
            square_trigger <= (state_next == PLAY) && (active_next == ID_HIT);
            noise_trigger  <= (state_next == PLAY) && (active_next == ID_DIE);
            busy           <= (state_next != IDLE);
        end
    end

    // active_reg is forced to none whenever the state leaves PLAY.
    assign active_id = active_reg;

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Directed bench for sound_event_scheduler: priority, lengths, gap, retrigger, mute and reset.
module tb_sound_event_scheduler;

    localparam int SPACING = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_end = 1'b0;
    logic       eat_req = 1'b0;
    logic       hit_req = 1'b0;
    logic       die_req = 1'b0;
    logic       mute = 1'b0;
    logic       saw_trigger, square_trigger, noise_trigger, busy;
    logic [1:0] active_id;

    int checks = 0;
    int errors = 0;

    sound_event_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .frame_end      (frame_end),
        .eat_req        (eat_req),
        .hit_req        (hit_req),
        .die_req        (die_req),
        .mute           (mute),
        .saw_trigger    (saw_trigger),
        .square_trigger (square_trigger),
        .noise_trigger  (noise_trigger),
        .busy           (busy),
        .active_id      (active_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Frame pulses are spaced SPACING cycles apart; observation follows the pulse edge.
    task automatic frame_pulse();
        idle(SPACING - 1);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic test_reset();
        idle(3);
        checks++;
        if ({saw_trigger, square_trigger, noise_trigger, busy, active_id} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000",
                     {saw_trigger, square_trigger, noise_trigger, busy, active_id});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy got %b want 0", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_eat_length();
        eat_req = 1'b1;
        tick();
        checks++;
        if (saw_trigger !== 1'b0) begin
            errors++;
            $display("FAIL eat_latency_t1 saw got %b want 0", saw_trigger);
        end
        tick();
        checks++;
        if (saw_trigger !== 1'b1 || active_id !== 2'b01 || busy !== 1'b1) begin
            errors++;
            $display("FAIL eat_latency_t2 saw/id/busy got %b/%b/%b want 1/01/1",
                     saw_trigger, active_id, busy);
        end
        for (int i = 1; i <= 10; i++) begin
            frame_pulse();
            checks++;
            if (saw_trigger !== (i < 8) || busy !== (i < 10)) begin
                errors++;
                $display("FAIL eat_frame%0d saw/busy got %b/%b want %b/%b",
                         i, saw_trigger, busy, (i < 8), (i < 10));
            end
        end
        idle(5);
        checks++;
        if (busy !== 1'b0 || saw_trigger !== 1'b0) begin
            errors++;
            $display("FAIL eat_held_no_replay busy/saw got %b/%b want 0/0", busy, saw_trigger);
        end
        $display("test_eat_length done");
    endtask

    task automatic test_die_preempts_eat();
        eat_req = 1'b0;
        tick();
        eat_req = 1'b1;
        idle(2);
        checks++;
        if (saw_trigger !== 1'b1 || active_id !== 2'b01) begin
            errors++;
            $display("FAIL preempt_eat_start saw/id got %b/%b want 1/01", saw_trigger, active_id);
        end
        frame_pulse();
        frame_pulse();
        die_req = 1'b1;
        tick();
        die_req = 1'b0;
        checks++;
        if (saw_trigger !== 1'b1) begin
            errors++;
            $display("FAIL preempt_mid_cycle saw got %b want 1", saw_trigger);
        end
        tick();
        checks++;
        if (noise_trigger !== 1'b1 || saw_trigger !== 1'b0 || active_id !== 2'b11) begin
            errors++;
            $display("FAIL preempt_die noise/saw/id got %b/%b/%b want 1/0/11",
                     noise_trigger, saw_trigger, active_id);
        end
        for (int i = 1; i <= 32; i++) begin
            frame_pulse();
            checks++;
            if (noise_trigger !== (i < 30) || busy !== (i < 32) || saw_trigger !== 1'b0) begin
                errors++;
                $display("FAIL preempt_die_frame%0d noise/busy/saw got %b/%b/%b want %b/%b/0",
                         i, noise_trigger, busy, saw_trigger, (i < 30), (i < 32));
            end
        end
        idle(5);
        checks++;
        if (saw_trigger !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL preempt_eat_dropped saw/busy got %b/%b want 0/0", saw_trigger, busy);
        end
        eat_req = 1'b0;
        $display("test_die_preempts_eat done");
    endtask

    task automatic test_hit_waits_for_die();
        die_req = 1'b1;
        tick();
        die_req = 1'b0;
        tick();
        hit_req = 1'b1;
        tick();
        hit_req = 1'b0;
        tick();
        checks++;
        if (noise_trigger !== 1'b1 || square_trigger !== 1'b0) begin
            errors++;
            $display("FAIL hit_held noise/square got %b/%b want 1/0", noise_trigger, square_trigger);
        end
        for (int i = 1; i <= 32; i++) begin
            frame_pulse();
            checks++;
            if (noise_trigger !== (i < 30) || square_trigger !== 1'b0 || busy !== (i < 32)) begin
                errors++;
                $display("FAIL hit_wait_frame%0d noise/square/busy got %b/%b/%b want %b/0/%b",
                         i, noise_trigger, square_trigger, busy, (i < 30), (i < 32));
            end
        end
        tick();
        checks++;
        if (square_trigger !== 1'b1 || active_id !== 2'b10) begin
            errors++;
            $display("FAIL hit_granted square/id got %b/%b want 1/10", square_trigger, active_id);
        end
        for (int i = 1; i <= 14; i++) begin
            frame_pulse();
            checks++;
            if (square_trigger !== (i < 12) || busy !== (i < 14)) begin
                errors++;
                $display("FAIL hit_frame%0d square/busy got %b/%b want %b/%b",
                         i, square_trigger, busy, (i < 12), (i < 14));
            end
        end
        $display("test_hit_waits_for_die done");
    endtask

    task automatic test_retrigger();
        hit_req = 1'b1;
        tick();
        hit_req = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) frame_pulse();
        hit_req = 1'b1;
        tick();
        hit_req = 1'b0;
        checks++;
        if (square_trigger !== 1'b1) begin
            errors++;
            $display("FAIL retrig_edge square got %b want 1", square_trigger);
        end
        tick();
        checks++;
        if (square_trigger !== 1'b1) begin
            errors++;
            $display("FAIL retrig_reload square got %b want 1", square_trigger);
        end
        for (int i = 1; i <= 14; i++) begin
            frame_pulse();
            checks++;
            if (square_trigger !== (i < 12) || busy !== (i < 14)) begin
                errors++;
                $display("FAIL retrig_frame%0d square/busy got %b/%b want %b/%b",
                         i, square_trigger, busy, (i < 12), (i < 14));
            end
        end
        $display("test_retrigger done");
    endtask

    task automatic test_simultaneous();
        eat_req = 1'b1;
        hit_req = 1'b1;
        tick();
        eat_req = 1'b0;
        hit_req = 1'b0;
        tick();
        checks++;
        if (square_trigger !== 1'b1 || saw_trigger !== 1'b0 || active_id !== 2'b10) begin
            errors++;
            $display("FAIL simul_hit_first square/saw/id got %b/%b/%b want 1/0/10",
                     square_trigger, saw_trigger, active_id);
        end
        for (int i = 1; i <= 14; i++) begin
            frame_pulse();
            checks++;
            if (square_trigger !== (i < 12) || saw_trigger !== 1'b0 || busy !== (i < 14)) begin
                errors++;
                $display("FAIL simul_hit_frame%0d square/saw/busy got %b/%b/%b want %b/0/%b",
                         i, square_trigger, saw_trigger, busy, (i < 12), (i < 14));
            end
        end
        tick();
        checks++;
        if (saw_trigger !== 1'b1 || active_id !== 2'b01) begin
            errors++;
            $display("FAIL simul_eat_after saw/id got %b/%b want 1/01", saw_trigger, active_id);
        end
        for (int i = 1; i <= 10; i++) begin
            frame_pulse();
            checks++;
            if (saw_trigger !== (i < 8) || busy !== (i < 10)) begin
                errors++;
                $display("FAIL simul_eat_frame%0d saw/busy got %b/%b want %b/%b",
                         i, saw_trigger, busy, (i < 8), (i < 10));
            end
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_die_preempts_gap();
        eat_req = 1'b1;
        tick();
        eat_req = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) frame_pulse();
        checks++;
        if (busy !== 1'b1 || saw_trigger !== 1'b0 || active_id !== 2'b00) begin
            errors++;
            $display("FAIL gap_state busy/saw/id got %b/%b/%b want 1/0/00", busy, saw_trigger, active_id);
        end
        die_req = 1'b1;
        tick();
        die_req = 1'b0;
        tick();
        checks++;
        if (noise_trigger !== 1'b1 || active_id !== 2'b11) begin
            errors++;
            $display("FAIL gap_die_grant noise/id got %b/%b want 1/11", noise_trigger, active_id);
        end
        mute = 1'b1;
        tick();
        mute = 1'b0;
        checks++;
        if (busy !== 1'b0 || noise_trigger !== 1'b0) begin
            errors++;
            $display("FAIL gap_mute_cleanup busy/noise got %b/%b want 0/0", busy, noise_trigger);
        end
        $display("test_die_preempts_gap done");
    endtask

    task automatic test_mute_and_reset();
        die_req = 1'b1;
        tick();
        die_req = 1'b0;
        tick();
        mute = 1'b1;
        eat_req = 1'b1;
        tick();
        checks++;
        if ({saw_trigger, square_trigger, noise_trigger, busy, active_id} !== 6'b0) begin
            errors++;
            $display("FAIL mute_outputs got %b want 000000",
                     {saw_trigger, square_trigger, noise_trigger, busy, active_id});
        end
        idle(3);
        mute = 1'b0;
        idle(5);
        checks++;
        if (saw_trigger !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mute_discard saw/busy got %b/%b want 0/0", saw_trigger, busy);
        end
        eat_req = 1'b0;
        tick();
        eat_req = 1'b1;
        idle(2);
        checks++;
        if (saw_trigger !== 1'b1) begin
            errors++;
            $display("FAIL mute_fresh_edge saw got %b want 1", saw_trigger);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({saw_trigger, square_trigger, noise_trigger, busy, active_id} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_sound got %b want 000000",
                     {saw_trigger, square_trigger, noise_trigger, busy, active_id});
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_pending busy got %b want 0", busy);
        end
        tick();
        checks++;
        if (saw_trigger !== 1'b1 || active_id !== 2'b01) begin
            errors++;
            $display("FAIL reset_held_req_edge saw/id got %b/%b want 1/01", saw_trigger, active_id);
        end
        eat_req = 1'b0;
        $display("test_mute_and_reset done");
    endtask

    initial begin
        test_reset();
        test_eat_length();
        test_die_preempts_eat();
        test_hit_waits_for_die();
        test_retrigger();
        test_simultaneous();
        test_die_preempts_gap();
        test_mute_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
